// File: rtl/bus_arb2_64.sv
// bus_arb2_64: two-requester round-robin arbiter driving a 64-bit 2:1 mux into a one-entry valid/ready output register
module bus_arb2_64 #(
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t        r_state;
  logic          r_pri;
  logic          r_sel;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;
  logic          w_free;
  logic          w_win_v;
  logic          w_win;
  always_comb begin
    w_free  = (r_state == IDLE) | out_ready;
    w_win_v = rst_n & w_free & (req0 | req1);
    w_win   = (req0 & req1) ? r_pri : req1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pri   <= 1'b0;
      r_sel   <= 1'b0;
      r_data  <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else if (w_win_v) begin
      r_state <= HOLD;
      r_data  <= w_win ? data1 : data0;
      r_pri   <= ~w_win;
      r_sel   <= w_win;
      if (!w_win && !(&r_cnt0)) r_cnt0 <= r_cnt0 + CW'(1);
      if (w_win && !(&r_cnt1)) r_cnt1 <= r_cnt1 + CW'(1);
    end else if (w_free) begin
      r_state <= IDLE;
    end
  end
  assign gnt0      = w_win_v & ~w_win;
  assign gnt1      = w_win_v & w_win;
  assign sel       = w_win_v ? w_win : r_sel;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;
endmodule

// File: tb/tb_bus_arb2_64.sv
// tb_bus_arb2_64: directed scenario tests for bus_arb2_64
module tb_bus_arb2_64;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req0 = 0, req1 = 0, out_ready = 0;
  logic [63:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, sel, out_valid;
  logic [63:0] out_data;
  logic [15:0] cnt0, cnt1;
  int          pass_cnt = 0, total = 0;
  bus_arb2_64 dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req0 = 0; req1 = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0 || sel !== 1'b0 || cnt0 !== 16'h0 || out_data !== 64'h0)
      $display("FAIL reset_init got valid=%0b sel=%0b cnt0=%h data=%h exp 0", out_valid, sel, cnt0, out_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1; req0 = 1; data0 = 64'h1234; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req0 = 0;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 64'h1234)
      $display("FAIL reset_hold got valid=%0b data=%h exp 1/1234", out_valid, out_data); else pass_cnt++;
    req0 = 1; req1 = 1;
    #1 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 64'h0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || cnt0 !== 16'h0 || sel !== 1'b0)
      $display("FAIL reset_async got valid=%0b data=%h g=%0b%0b cnt0=%h sel=%0b exp all 0", out_valid, out_data, gnt0, gnt1, cnt0, sel); else pass_cnt++;
    req0 = 0; req1 = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0)
        $display("FAIL reset_idle%0d got valid=%0b g=%0b%0b exp 0", i, out_valid, gnt0, gnt1); else pass_cnt++;
    end
  endtask
  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1; data0 = 64'hA0 + 64'(i); out_ready = 1;
      #1;
      total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0)
        $display("FAIL stream_gnt%0d got g=%0b%0b sel=%0b exp 10/0", i, gnt0, gnt1, sel); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== 64'hA0 + 64'(i))
        $display("FAIL stream_data%0d got %0b/%h exp 1/%h", i, out_valid, out_data, 64'hA0 + 64'(i)); else pass_cnt++;
    end
    @(negedge clk);
    req0 = 0;
    #1;
    total++; if (cnt0 !== 16'd4 || cnt1 !== 16'd0 || sel !== 1'b0)
      $display("FAIL stream_cnt got cnt0=%0d cnt1=%0d sel=%0b exp 4/0/0", cnt0, cnt1, sel); else pass_cnt++;
  endtask
  task automatic test_contend();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic e;
      e = i[0];
      @(negedge clk);
      req0 = 1; req1 = 1; out_ready = 1;
      data0 = 64'h1; data1 = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      total++; if (gnt0 !== ~e || gnt1 !== e || sel !== e)
        $display("FAIL contend_gnt%0d got g=%0b%0b sel=%0b exp g1=%0b", i, gnt0, gnt1, sel, e); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (out_data !== (e ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1))
        $display("FAIL contend_data%0d got %h", i, out_data); else pass_cnt++;
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    #1;
    total++; if (cnt0 !== 16'd3 || cnt1 !== 16'd3)
      $display("FAIL contend_cnt got %0d/%0d exp 3/3", cnt0, cnt1); else pass_cnt++;
  endtask
  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req0 = 1; data0 = 64'hDEAD; out_ready = 0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0 = 0; req1 = 1; data1 = 64'hBEEF; out_ready = 0;
      #1;
      total++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'hDEAD)
        $display("FAIL bp_hold%0d got g=%0b%0b valid=%0b data=%h exp 00/1/dead", i, gnt0, gnt1, out_valid, out_data); else pass_cnt++;
    end
    @(negedge clk);
    out_ready = 1;
    #1;
    total++; if (gnt1 !== 1'b1 || sel !== 1'b1)
      $display("FAIL bp_gnt got gnt1=%0b sel=%0b exp 1/1", gnt1, sel); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 64'hBEEF || cnt1 !== 16'd1)
      $display("FAIL bp_capture got valid=%0b data=%h cnt1=%0d exp 1/beef/1", out_valid, out_data, cnt1); else pass_cnt++;
    @(negedge clk);
    req1 = 0;
    #1;
    total++; if (gnt1 !== 1'b0 || sel !== 1'b1)
      $display("FAIL bp_single got gnt1=%0b sel=%0b exp 0/1", gnt1, sel); else pass_cnt++;
  endtask
  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    req0 = 1; data0 = 64'h5; out_ready = 1;
    repeat (65534) @(posedge clk);
    #1;
    total++; if (cnt0 !== 16'hFFFE)
      $display("FAIL sat_pre got %h exp fffe", cnt0); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (cnt0 !== 16'hFFFF || cnt1 !== 16'h0)
      $display("FAIL sat_hold got cnt0=%h cnt1=%h exp ffff/0", cnt0, cnt1); else pass_cnt++;
    @(negedge clk);
    req0 = 0;
  endtask
  task automatic test_withdraw();
    do_reset();
    @(negedge clk);
    req0 = 1; data0 = 64'h55; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req0 = 1; data0 = 64'h66; req1 = 1; data1 = 64'h77;
    #1;
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0)
      $display("FAIL wd_nogrant got g=%0b%0b exp 00", gnt0, gnt1); else pass_cnt++;
    @(negedge clk);
    req1 = 0; out_ready = 1;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0)
      $display("FAIL wd_next got g=%0b%0b sel=%0b exp 10/0", gnt0, gnt1, sel); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (out_data !== 64'h66 || cnt0 !== 16'd2 || cnt1 !== 16'd0)
      $display("FAIL wd_cnt got data=%h cnt0=%0d cnt1=%0d exp 66/2/0", out_data, cnt0, cnt1); else pass_cnt++;
    @(negedge clk);
    req0 = 0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_contend();
    test_backpressure();
    test_saturation();
    test_withdraw();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
